// File: rtl/tty_pkg.sv
// Shared teletype definitions: receiver FSM states and default character framing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tty_pkg;

    // Character framing defaults, shared with the transmitter side.
    localparam int unsigned TTY_DATA_BITS  = 8;
    localparam int unsigned TTY_OVERSAMPLE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with rising-edge detector for one asynchronous input.
// Latency: level_o lags d_i by 2 clk; tick_o pulses for 1 clk on the cycle level_o rises.
// Backpressure: none; free-running.
//
// Ports:
//   clk, rst_n : core clock and async active-low reset (all flops reset to 1)
//   d_i        : asynchronous input
//   level_o    : synchronized level
//   tick_o     : one-cycle pulse per synchronized rising edge
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic tick_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resetting to 1 models an idle-high line and guarantees no tick
    // straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign tick_o  = sync_q & ~prev_q;

endmodule

// File: rtl/tty_rx_8x.sv
// Async serial receiver clocked by an 8x-baud strobe; delivers one character with ready/error flags.
// Latency: outputs update 1 clk after the baud tick that samples the middle of the stop bit.
// Backpressure: none; a character landing on an unread flag sets ovr and overwrites data.
//
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   baud8      : 8x-baud square wave (asynchronous)
//   rxd        : serial line, idle high, LSB first
//   clr_flag   : one-cycle pulse; clears flag, ferr, ovr
//   data       : last received character
//   flag/ferr/ovr : character ready / stop bit low / overrun
//   busy       : receiver is inside a frame
module tty_rx_8x
    import tty_pkg::*;
#(
    parameter int unsigned DATA_BITS  = TTY_DATA_BITS,
    parameter int unsigned OVERSAMPLE = TTY_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud8,
    input  logic                 rxd,
    input  logic                 clr_flag,
    output logic [DATA_BITS-1:0] data,
    output logic                 flag,
    output logic                 ferr,
    output logic                 ovr,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    logic baud_lvl_unused;
    logic tick;
    logic rxd_s;
    logic rxd_rise_unused;

    sync_rise u_baud_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (baud8),
        .level_o (baud_lvl_unused),
        .tick_o  (tick)
    );

    sync_rise u_rxd_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (rxd),
        .level_o (rxd_s),
        .tick_o  (rxd_rise_unused)
    );

    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bitn_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 flag_q;
    logic                 ferr_q;
    logic                 ovr_q;
    // Set after a low stop bit; blocks start detection until the line is
    // seen high again so a held break is not decoded as a stream of 0x00.
    logic                 brk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            if (clr_flag) begin
                flag_q <= 1'b0;
                ferr_q <= 1'b0;
                ovr_q  <= 1'b0;
            end

            // Everything below overrides the clear above: a completion in
            // the same cycle as clr_flag wins.
            if (tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (brk_q) begin
                            if (rxd_s) begin
                                brk_q <= 1'b0;
                            end
                        end else if (!rxd_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        if (cnt_q == CNT_MID) begin
                            // Mid start bit: a line already back high was a glitch.
                            if (rxd_s) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= DATA;
                                cnt_q   <= '0;
                                bitn_q  <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            shreg_q <= {rxd_s, shreg_q[DATA_BITS-1:1]};
                            cnt_q   <= '0;
                            bitn_q  <= bitn_q + BIT_ONE;
                            if (bitn_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            data_q  <= shreg_q;
                            flag_q  <= 1'b1;
                            ferr_q  <= ~rxd_s;
                            // A simultaneous clear consumes the old character.
                            ovr_q   <= clr_flag ? 1'b0 : (ovr_q | flag_q);
                            brk_q   <= ~rxd_s;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign data = data_q;
    assign flag = flag_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;
    assign busy = (state_q != IDLE);

endmodule
